// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: synchronous FIFO controller driving a dual-port RAM
// (port A write, port B read) with a 2-entry skid buffer that hides the
// RAM's 1-cycle read latency and gives a first-word-fall-through output.
// Optional feature macro: DPRAM_FIFO_ALMOST_EN adds a registered
// almost_full_out flag (level_out >= AF_THRESH).
module dpram_fifo_ctrl #(
   parameter int DWIDTH    = 32,
   parameter int AWIDTH    = 5,
   parameter int AF_THRESH = 28
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              wr_valid_in,
   output logic              wr_ready_out,
   input  logic [DWIDTH-1:0] wr_data_in,
   output logic              rd_valid_out,
   input  logic              rd_ready_in,
   output logic [DWIDTH-1:0] rd_data_out,
   output logic [AWIDTH+1:0] level_out,
   output logic              en_a_out,
   output logic              we_a_out,
   output logic [AWIDTH-1:0] addr_a_out,
   output logic [DWIDTH-1:0] d_a_out,
   output logic              en_b_out,
   output logic              we_b_out,
   output logic [AWIDTH-1:0] addr_b_out,
   input  logic [DWIDTH-1:0] d_b_in
`ifdef DPRAM_FIFO_ALMOST_EN
   ,
   output logic              almost_full_out
`endif
);

   localparam int              DEPTH   = 2**AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_P = (AWIDTH+1)'(DEPTH);

   logic [AWIDTH:0]   wptr_q, wptr_d;
   logic [AWIDTH:0]   rptr_q, rptr_d;
   logic [AWIDTH:0]   ram_cnt, ram_cnt_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        skid_cnt_q, skid_cnt_d;
   logic [DWIDTH-1:0] skid0_q, skid0_d;
   logic [DWIDTH-1:0] skid1_q, skid1_d;
   logic [AWIDTH+1:0] level_q, level_d;
   logic              wr_fire, rd_pop, rd_issue;
   logic [2:0]        occ_after_pop;

   // Words in RAM; wrap bit makes full and empty distinguishable.
   assign ram_cnt      = wptr_q - rptr_q;
   assign wr_ready_out = (ram_cnt != DEPTH_P);
   assign wr_fire      = wr_valid_in & wr_ready_out;

   assign rd_valid_out = (skid_cnt_q != 2'd0);
   assign rd_data_out  = skid0_q;
   assign rd_pop       = rd_valid_out & rd_ready_in;

   // Skid slots committed once this cycle's pop is taken into account.
   assign occ_after_pop = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, rd_pop};
   // Registered wptr means a word is issuable one cycle after its write,
   // so ports A and B never touch the same address in the same cycle.
   assign rd_issue      = (ram_cnt != '0) && (occ_after_pop < 3'd2);

   assign en_a_out   = wr_fire;
   assign we_a_out   = wr_fire;
   assign addr_a_out = wr_fire ? wptr_q[AWIDTH-1:0] : '0;
   assign d_a_out    = wr_fire ? wr_data_in : '0;

   assign en_b_out   = rd_issue;
   assign we_b_out   = 1'b0;
   assign addr_b_out = rd_issue ? rptr_q[AWIDTH-1:0] : '0;

   assign level_out  = level_q;

   // Next-state: pointers, in-flight flag, skid shift/capture and level.
   always_comb begin
      wptr_d     = wptr_q + (AWIDTH+1)'(wr_fire);
      rptr_d     = rptr_q + (AWIDTH+1)'(rd_issue);
      inflight_d = rd_issue;
      skid0_d    = skid0_q;
      skid1_d    = skid1_q;
      skid_cnt_d = skid_cnt_q;
      // Pop first, then capture into the first free slot; a simultaneous
      // pop and capture leaves the count unchanged.
      if (rd_pop) begin
         skid0_d    = skid1_q;
         skid_cnt_d = skid_cnt_q - 2'd1;
      end
      if (inflight_q) begin
         if (skid_cnt_d == 2'd0) begin
            skid0_d = d_b_in;
         end else begin
            skid1_d = d_b_in;
         end
         skid_cnt_d = skid_cnt_d + 2'd1;
      end
      ram_cnt_d = wptr_d - rptr_d;
      level_d   = (AWIDTH+2)'(ram_cnt_d) + (AWIDTH+2)'(inflight_d)
                + (AWIDTH+2)'(skid_cnt_d);
   end

   // State registers with synchronous reset; in-flight read data is dropped.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         inflight_q <= 1'b0;
         skid_cnt_q <= 2'd0;
         skid0_q    <= '0;
         skid1_q    <= '0;
         level_q    <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         inflight_q <= inflight_d;
         skid_cnt_q <= skid_cnt_d;
         skid0_q    <= skid0_d;
         skid1_q    <= skid1_d;
         level_q    <= level_d;
      end
   end

`ifdef DPRAM_FIFO_ALMOST_EN
   localparam logic [AWIDTH+1:0] AF_LVL = (AWIDTH+2)'(AF_THRESH);
   logic af_q;

   // Almost-full flag tracks the next level so it aligns with level_out.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         af_q <= 1'b0;
      end else begin
         af_q <= (level_d >= AF_LVL);
      end
   end

   assign almost_full_out = af_q;
`endif

endmodule
